// File: rtl/asm_scan_controller_pkg.sv
// Shared types for the assembler scan controller.
// Holds the assembler pass encoding and a busy helper.
package asm_scan_controller_pkg;

  typedef enum logic [2:0] {
    IDLE                = 3'd0,
    PC_MAPPING          = 3'd1,
    INSTRUCTION_MAPPING = 3'd2,
    SUCCESS             = 3'd3,
    ERROR               = 3'd4
  } assembler_state_t;

  function automatic logic is_busy(
    input assembler_state_t s
  );
    return (s == PC_MAPPING) ||
           (s == INSTRUCTION_MAPPING);
  endfunction

endpackage

// File: rtl/asm_scan_controller_valid_pipe.sv
// Valid-bit shift register matching the RAM read latency.
// Ports: clk/rst_n, squash_in (sync clear), push_in, tail_out, any_out.
module asm_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic squash_in,
  input  logic push_in,
  output logic tail_out,
  output logic any_out
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    vld_d = (vld_q << 1) | DEPTH'(push_in);
    if (squash_in) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign tail_out = vld_q[DEPTH-1];
  assign any_out  = |vld_q;

endmodule

// File: rtl/asm_scan_controller.sv
// Two-pass scan of the editor character RAM into the assembler.
// In: clk_in, rst_n_in, start_in, char_in, line_done_in, line_error_in.
// Out: addr_out, new_line_out, new_char_out, char_out, pass_out,
//      busy_out, error_line_out.
module asm_scan_controller
  import asm_scan_controller_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 64,
  parameter int SCREEN_HEIGHT = 64,
  parameter int READ_LATENCY  = 2,
  localparam int AW = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  localparam int LW = $clog2(SCREEN_HEIGHT),
  localparam int CW = $clog2(SCREEN_WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [7:0]       char_in,
  input  logic             line_done_in,
  input  logic             line_error_in,
  output logic [AW-1:0]    addr_out,
  output logic             new_line_out,
  output logic             new_char_out,
  output logic [7:0]       char_out,
  output assembler_state_t pass_out,
  output logic             busy_out,
  output logic [LW-1:0]    error_line_out
);

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_START = 3'd1,
    L_PULSE = 3'd2,
    L_ISSUE = 3'd3,
    L_DRAIN = 3'd4
  } line_state_t;

  logic             start_q, start_d;
  assembler_state_t pass_q, pass_d;
  line_state_t      lst_q, lst_d;
  logic [LW-1:0]    line_q, line_d;
  logic [CW-1:0]    col_q, col_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             nl_q, nl_d;
  logic [LW-1:0]    eline_q, eline_d;

  logic start_edge;
  logic busy;
  logic done_hit;
  logic eol;
  logic push;
  logic squash;
  logic vld_tail;
  logic vld_any;

  assign start_edge = start_in & ~start_q;
  assign busy       = is_busy(pass_q);
  assign done_hit   = line_done_in &
                      ((lst_q == L_ISSUE) ||
                       (lst_q == L_DRAIN));
  assign eol        = done_hit ||
                      ((lst_q == L_DRAIN) && !vld_any);

  always_comb begin
    start_d = start_in;
    pass_d  = pass_q;
    lst_d   = lst_q;
    line_d  = line_q;
    col_d   = col_q;
    addr_d  = addr_q;
    nl_d    = 1'b0;
    eline_d = eline_q;
    push    = 1'b0;
    squash  = 1'b0;
    if (start_edge) begin
      pass_d = PC_MAPPING;
      lst_d  = L_START;
      line_d = '0;
      col_d  = '0;
      addr_d = '0;
      squash = 1'b1;
    end else if (busy && line_error_in) begin
      pass_d  = ERROR;
      lst_d   = L_IDLE;
      eline_d = line_q;
      squash  = 1'b1;
    end else if (busy) begin
      unique case (lst_q)
        L_START: begin
          addr_d = {line_q, CW'(0)};
          nl_d   = 1'b1;
          lst_d  = L_PULSE;
        end
        L_PULSE: lst_d = L_ISSUE;
        L_ISSUE: begin
          push = 1'b1;
          if (col_q == CW'(SCREEN_WIDTH-1)) begin
            lst_d = L_DRAIN;
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
        L_DRAIN: ;
        L_IDLE:  ;
        default: ;
      endcase
      if (eol) begin
        // done drops any reads still in flight for this line
        squash = 1'b1;
        col_d  = '0;
        if (line_q != LW'(SCREEN_HEIGHT-1)) begin
          line_d = line_q + LW'(1);
          lst_d  = L_START;
        end else if (pass_q == PC_MAPPING) begin
          pass_d = INSTRUCTION_MAPPING;
          line_d = '0;
          lst_d  = L_START;
        end else begin
          pass_d = SUCCESS;
          lst_d  = L_IDLE;
        end
      end
    end
  end

  // start_q resets high so a start held across reset is not an edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      start_q <= 1'b1;
      pass_q  <= IDLE;
      lst_q   <= L_IDLE;
      line_q  <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      nl_q    <= 1'b0;
      eline_q <= '0;
    end else begin
      start_q <= start_d;
      pass_q  <= pass_d;
      lst_q   <= lst_d;
      line_q  <= line_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      nl_q    <= nl_d;
      eline_q <= eline_d;
    end
  end

  asm_valid_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_vpipe (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .squash_in (squash),
    .push_in   (push),
    .tail_out  (vld_tail),
    .any_out   (vld_any)
  );

  assign addr_out       = addr_q;
  assign new_line_out   = nl_q;
  assign new_char_out   = vld_tail;
  assign char_out       = vld_tail ? char_in : 8'h00;
  assign pass_out       = pass_q;
  assign busy_out       = busy;
  assign error_line_out = eline_q;

endmodule
